// File: rtl/cic_multi_regs.sv
// cic_multi_regs: per-channel shadow/active CIC control registers with atomic apply
module cic_multi_regs #(
  parameter int NUM_CH      = 4,
  parameter int DEC_W       = 15,
  parameter int SHIFT_W     = 6,
  parameter int ADDR_W      = 13,
  parameter int DEC_RESET   = 4,
  parameter int SHIFT_RESET = 0,
  parameter int MIN_DEC     = 2
) (
  input  logic                      busClk,
  input  logic                      nReset,
  input  logic                      cs,
  input  logic                      wr0,
  input  logic                      wr1,
  input  logic                      wr2,
  input  logic                      wr3,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [31:0]               dataIn,
  output logic [31:0]               dataOut,
  input  logic [NUM_CH-1:0]         cicStrobe,
  output logic [NUM_CH*DEC_W-1:0]   cicDecimation,
  output logic [NUM_CH*SHIFT_W-1:0] cicShift,
  output logic [NUM_CH-1:0]         cicLoad
);
  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;
  logic [3:0] ch;
  logic [1:0] rsel;
  logic [NUM_CH-1:0][31:0] rd_word;
  logic unused_bits;
  assign ch = addr[7:4];
  assign rsel = addr[3:2];
  assign unused_bits = ^{addr[ADDR_W-1:8], addr[1:0], wr2, wr3, dataIn[31:16]};
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      state_t state, state_nx;
      logic [DEC_W-1:0] sh_dec, act_dec, dec_new;
      logic [SHIFT_W-1:0] sh_shift, act_shift;
      logic [15:0] dec_pad;
      logic hit, apply, commit_ok, imm, err, load;
      assign hit = cs && ch == 4'(c);
      assign apply = hit && rsel == 2'd2 && wr0 && dataIn[0];
      assign commit_ok = state == COMMIT && sh_dec >= DEC_W'(MIN_DEC);
      assign dec_pad = 16'(sh_dec);
      assign dec_new = DEC_W'({wr1 ? dataIn[15:8] : dec_pad[15:8], wr0 ? dataIn[7:0] : dec_pad[7:0]});
      // apply sequencing: immediate applies and strobes both lead to a one-cycle commit
      always_comb begin
        state_nx = state == COMMIT ? IDLE :
                   state == IDLE ? (apply ? (dataIn[1] ? COMMIT : PENDING) : IDLE) :
                   (cicStrobe[c] || (apply && dataIn[1])) ? COMMIT : PENDING;
      end
      // state register; reset cancels any pending apply
      always_ff @(posedge busClk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else state <= state_nx;
      end
      // shadow writes, atomic copy to active, error and immediate flags
      always_ff @(posedge busClk or negedge nReset) begin
        if (!nReset) begin
          sh_dec    <= DEC_W'(DEC_RESET);
          act_dec   <= DEC_W'(DEC_RESET);
          sh_shift  <= SHIFT_W'(SHIFT_RESET);
          act_shift <= SHIFT_W'(SHIFT_RESET);
          imm       <= 1'b0;
          err       <= 1'b0;
          load      <= 1'b0;
        end else begin
          if (hit && rsel == 2'd0 && (wr0 || wr1)) sh_dec <= dec_new;
          if (hit && rsel == 2'd1 && wr0) sh_shift <= dataIn[SHIFT_W-1:0];
          if (commit_ok) begin
            act_dec   <= sh_dec;
            act_shift <= sh_shift;
          end
          load <= commit_ok;
          if (state == COMMIT && !commit_ok) err <= 1'b1;
          else if (hit && rsel == 2'd2 && wr1 && dataIn[8]) err <= 1'b0;
          if (apply && (state == IDLE || (state == PENDING && dataIn[1]))) imm <= dataIn[1];
        end
      end
      assign cicDecimation[c*DEC_W +: DEC_W] = act_dec;
      assign cicShift[c*SHIFT_W +: SHIFT_W] = act_shift;
      assign cicLoad[c] = load;
      assign rd_word[c] = !hit ? 32'd0 :
                          rsel == 2'd0 ? 32'(sh_dec) :
                          rsel == 2'd1 ? 32'(sh_shift) :
                          rsel == 2'd2 ? {23'd0, err, 6'd0, imm, state == PENDING} :
                          {8'd0, 8'(act_shift), 16'(act_dec)};
    end
  endgenerate
  // at most one channel is selected, so OR-ing the per-channel words forms the read mux
  always_comb begin
    dataOut = 32'd0;
    for (int i = 0; i < NUM_CH; i++) dataOut = dataOut | rd_word[i];
  end
endmodule

// File: tb/tb_cic_multi_regs.sv
// tb_cic_multi_regs: randomized and directed checks against a transaction-level register model
module tb_cic_multi_regs;
  localparam int NCH = 4, DW = 15, SW = 6, AW = 13;
  logic busClk = 0, nReset = 0, cs = 0, wr0 = 0, wr1 = 0, wr2 = 0, wr3 = 0;
  logic [AW-1:0] addr = '0;
  logic [31:0] dataIn = '0, dataOut, rd;
  logic [NCH-1:0] cicStrobe = '0, cicLoad;
  logic [NCH*DW-1:0] cicDecimation;
  logic [NCH*SW-1:0] cicShift;
  int errors = 0, checks = 0, cyc = 0;
  int sh_dec[NCH], sh_sh[NCH], act_dec[NCH], act_sh[NCH], due[NCH];
  bit pend[NCH], imm[NCH], err[NCH], load[NCH];

  cic_multi_regs dut (
    .busClk(busClk), .nReset(nReset), .cs(cs),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
    .cicStrobe(cicStrobe), .cicDecimation(cicDecimation),
    .cicShift(cicShift), .cicLoad(cicLoad)
  );

  always #5 busClk = ~busClk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (step %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      sh_dec[c] = 4; act_dec[c] = 4; sh_sh[c] = 0; act_sh[c] = 0;
      due[c] = -1; pend[c] = 0; imm[c] = 0; err[c] = 0; load[c] = 0;
    end
  endtask

  function automatic logic [31:0] model_read();
    int ch, r;
    ch = int'(addr[7:4]);
    r = int'(addr[3:2]);
    if (!cs || ch >= NCH) return 0;
    case (r)
      0: return sh_dec[ch];
      1: return sh_sh[ch];
      2: return (int'(err[ch]) << 8) | (int'(imm[ch]) << 1) | int'(pend[ch]);
      default: return (act_sh[ch] << 16) | act_dec[ch];
    endcase
  endfunction

  // one clock edge: a copy scheduled for this edge uses the shadow as it was before the edge
  task automatic model_edge();
    int ch, r, od, os;
    bit busy, p0, eset, hit, ap, im;
    ch = int'(addr[7:4]);
    r = int'(addr[3:2]);
    for (int c = 0; c < NCH; c++) begin
      busy = due[c] == cyc;
      p0 = pend[c];
      eset = 0;
      hit = cs && ch == c;
      od = sh_dec[c];
      os = sh_sh[c];
      load[c] = 0;
      if (busy) begin
        due[c] = -1;
        if (od >= 2) begin act_dec[c] = od; act_sh[c] = os; load[c] = 1; end
        else begin err[c] = 1; eset = 1; end
      end
      if (hit && r == 0) begin
        if (wr0) sh_dec[c] = (sh_dec[c] & 'hff00) | int'(dataIn[7:0]);
        if (wr1) sh_dec[c] = (sh_dec[c] & 'h00ff) | (int'(dataIn[15:8]) << 8);
        sh_dec[c] = sh_dec[c] & ((1 << DW) - 1);
      end
      if (hit && r == 1 && wr0) sh_sh[c] = int'(dataIn) & ((1 << SW) - 1);
      ap = hit && r == 2 && wr0 && dataIn[0];
      im = dataIn[1];
      if (hit && r == 2 && wr1 && dataIn[8] && !eset) err[c] = 0;
      if (!busy && !p0 && ap) begin
        if (im) begin due[c] = cyc + 1; imm[c] = 1; end
        else begin pend[c] = 1; imm[c] = 0; end
      end
      if (p0 && ((ap && im) || cicStrobe[c])) begin
        pend[c] = 0;
        due[c] = cyc + 1;
        if (ap && im) imm[c] = 1;
      end
    end
    cyc++;
  endtask

  task automatic check_outs();
    logic [NCH*DW-1:0] ed;
    logic [NCH*SW-1:0] es;
    logic [NCH-1:0] el;
    for (int c = 0; c < NCH; c++) begin
      ed[c*DW +: DW] = DW'(act_dec[c]);
      es[c*SW +: SW] = SW'(act_sh[c]);
      el[c] = load[c];
    end
    check("cicDecimation", 64'(cicDecimation), 64'(ed));
    check("cicShift", 64'(cicShift), 64'(es));
    check("cicLoad", 64'(cicLoad), 64'(el));
  endtask

  task automatic step(input logic c_i, input logic [3:0] w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [NCH-1:0] st);
    @(negedge busClk);
    cs = c_i; {wr3, wr2, wr1, wr0} = w; addr = a; dataIn = d; cicStrobe = st;
    #1;
    rd = dataOut;
    check("dataOut", 64'(rd), 64'(model_read()));
    @(posedge busClk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, '0, 32'd0, '0);
  endtask

  task automatic rdreg(input logic [AW-1:0] a);
    step(1'b1, 4'd0, a, 32'd0, '0);
  endtask

  initial begin
    logic [3:0] chn, w;
    logic [1:0] r;
    logic [31:0] d;
    logic [NCH-1:0] st;
    model_reset();
    repeat (3) @(posedge busClk);
    @(negedge busClk);
    nReset = 1;
    check("rst_dec", 64'(cicDecimation), 64'({NCH{15'd4}}));
    check("rst_shift", 64'(cicShift), 64'd0);
    check("rst_load", 64'(cicLoad), 64'd0);
    rdreg('h00C);
    check("rst_active_rd", 64'(rd), 64'h4);
    step(1'b1, 4'b0011, 'h010, 32'h1234, '0);
    step(1'b1, 4'b0001, 'h018, 32'h3, '0);
    check("imm_not_yet", 64'(cicDecimation[DW +: DW]), 64'h4);
    idle(1);
    check("imm_dec", 64'(cicDecimation[DW +: DW]), 64'h1234);
    check("imm_load", 64'(cicLoad), 64'b0010);
    idle(1);
    check("imm_load_end", 64'(cicLoad), 64'd0);
    step(1'b1, 4'b0001, 'h024, 32'h9, '0);
    step(1'b1, 4'b0001, 'h028, 32'h1, '0);
    rdreg('h028);
    check("strb_pending", 64'(rd), 64'h1);
    idle(2);
    check("strb_wait", 64'(cicShift[2*SW +: SW]), 64'h0);
    step(1'b0, 4'd0, '0, 32'd0, 4'b0100);
    check("strb_not_yet", 64'(cicShift[2*SW +: SW]), 64'h0);
    idle(1);
    check("strb_shift", 64'(cicShift[2*SW +: SW]), 64'h9);
    step(1'b1, 4'b0011, 'h000, 32'h1, '0);
    step(1'b1, 4'b0001, 'h008, 32'h3, '0);
    idle(1);
    check("bad_dec_kept", 64'(cicDecimation[0 +: DW]), 64'h4);
    check("bad_no_load", 64'(cicLoad), 64'd0);
    rdreg('h008);
    check("bad_err_set", 64'(rd[8]), 64'h1);
    step(1'b1, 4'b0010, 'h008, 32'h100, '0);
    rdreg('h008);
    check("bad_err_clr", 64'(rd[8]), 64'h0);
    step(1'b1, 4'b0011, 'h030, 32'h55, '0);
    step(1'b1, 4'b0001, 'h038, 32'h1, 4'b1000);
    idle(2);
    rdreg('h038);
    check("same_strb_pend", 64'(rd[0]), 64'h1);
    check("same_strb_dec", 64'(cicDecimation[3*DW +: DW]), 64'h4);
    step(1'b0, 4'd0, '0, 32'd0, 4'b1000);
    idle(1);
    check("same_strb_commit", 64'(cicDecimation[3*DW +: DW]), 64'h55);
    step(1'b1, 4'b0001, 'h034, 32'h7, '0);
    step(1'b1, 4'b0001, 'h038, 32'h1, '0);
    rdreg('h038);
    check("rst_pend_before", 64'(rd[0]), 64'h1);
    @(negedge busClk);
    nReset = 0;
    #1;
    model_reset();
    check_outs();
    @(negedge busClk);
    nReset = 1;
    rdreg('h038);
    check("rst_pend_clear", 64'(rd), 64'h0);
    rdreg('h034);
    check("rst_shadow_shift", 64'(rd), 64'h0);
    rdreg('h030);
    check("rst_shadow_dec", 64'(rd), 64'h4);
    for (int i = 0; i < 3000; i++) begin
      chn = ($urandom % 5 == 4) ? 4'($urandom_range(4, 15)) : 4'($urandom % 4);
      r = 2'($urandom);
      d = $urandom;
      if (r == 2'd0 && $urandom % 3 == 0) d[15:0] = 16'($urandom % 4);
      w = 4'($urandom);
      for (int c = 0; c < NCH; c++) st[c] = ($urandom % 6) == 0;
      step($urandom % 4 != 0, w, {5'($urandom), chn, r, 2'($urandom)}, d, st);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
